// File: rtl/wb_arbiter_pkg.sv
// Shared types and default sizing for the writeback arbiter slice.
// Owns the ex_update_t result record exchanged between functional units and writeback.
package wb_arbiter_pkg;

  localparam int unsigned WB_NUM_FU = 4;
  localparam int unsigned WB_DEPTH  = 8;
  localparam int unsigned WB_SKID   = 4;
  // One extra MSB distinguishes full from empty when the index bits match.
  localparam int unsigned WB_PTR_W  = $clog2(WB_DEPTH) + 1;

  typedef struct packed {
    logic        valid;
    logic [7:0]  ticket;
    logic [31:0] data;
    logic        valid_exception;
    logic [4:0]  cause;
  } ex_update_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-FU result FIFO, one ex_update_t wide, with wrap-bit pointers.
// Push into a full FIFO is dropped unless the same cycle pops; drop_o flags the loss.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned Depth = WB_DEPTH,
  localparam int unsigned PtrW = $clog2(Depth) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  ex_update_t      data_i,
  output ex_update_t      data_o,
  output logic            empty_o,
  output logic [PtrW-1:0] count_next_o,
  output logic            drop_o
);

  localparam int unsigned IdxW = PtrW - 1;

  ex_update_t      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW-1:0] count;
  logic            full;
  logic            do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                   (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;

  assign do_pop  = pop_i && !empty_o;
  // A simultaneous pop frees the slot, so push into a full FIFO is legal then.
  assign do_push = push_i && (!full || do_pop);
  assign drop_o  = push_i && full && !do_pop;

  assign count_next_o = count + PtrW'(do_push) - PtrW'(do_pop);
  assign data_o       = mem_q[rd_ptr_q[IdxW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[IdxW-1:0]] <= data_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter over per-FU result FIFOs with registered busy back to issue.
// Optional same-cycle bypass when every FIFO is empty: define WB_BYPASS_EN.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_FU = WB_NUM_FU,
  parameter int unsigned DEPTH  = WB_DEPTH,
  parameter int unsigned SKID   = WB_SKID
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  ex_update_t [NUM_FU-1:0] fu_update_i,
  output logic [NUM_FU-1:0]       busy_fu_o,
  output ex_update_t              wb_o,
  input  logic                    wb_ready_i,
  output logic                    overflow_o
);

  localparam int unsigned PtrW = $clog2(DEPTH) + 1;
  localparam int unsigned IdxW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  ex_update_t        head       [NUM_FU];
  logic [PtrW-1:0]   count_next [NUM_FU];
  logic [NUM_FU-1:0] empty, drop, push, pop;

  logic [IdxW-1:0]   rr_ptr_q;
  logic [NUM_FU-1:0] busy_q;
  logic              overflow_q;

  logic              req;
  logic [IdxW-1:0]   grant, win;

  function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] base, input int unsigned off);
    logic [31:0] sum;
    sum = 32'(base) + off;
    return IdxW'(sum % NUM_FU);
  endfunction

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
    wb_fifo #(
      .Depth(DEPTH)
    ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push[i]),
      .pop_i       (pop[i]),
      .data_i      (fu_update_i[i]),
      .data_o      (head[i]),
      .empty_o     (empty[i]),
      .count_next_o(count_next[i]),
      .drop_o      (drop[i])
    );
  end

  always_comb begin
    req   = 1'b0;
    grant = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      if (!req && !empty[rr_idx(rr_ptr_q, k)]) begin
        req   = 1'b1;
        grant = rr_idx(rr_ptr_q, k);
      end
    end
  end

`ifdef WB_BYPASS_EN
  logic            byp_req;
  logic [IdxW-1:0] byp_sel;

  always_comb begin
    byp_req = 1'b0;
    byp_sel = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      if (!byp_req && fu_update_i[rr_idx(rr_ptr_q, k)].valid) begin
        byp_req = 1'b1;
        byp_sel = rr_idx(rr_ptr_q, k);
      end
    end
  end
`endif

  always_comb begin
    wb_o = '0;
    win  = grant;
    pop  = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) push[i] = fu_update_i[i].valid;
    if (req) begin
      wb_o       = head[grant];
      wb_o.valid = 1'b1;
      if (wb_ready_i) pop[grant] = 1'b1;
`ifdef WB_BYPASS_EN
    end else if (byp_req) begin
      // All FIFOs empty: forward straight from the FU, store only if not taken now.
      wb_o       = fu_update_i[byp_sel];
      wb_o.valid = 1'b1;
      win        = byp_sel;
      if (wb_ready_i) push[byp_sel] = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      busy_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wb_o.valid && wb_ready_i) rr_ptr_q <= rr_idx(win, 1);
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        busy_q[i] <= (32'(count_next[i]) >= (DEPTH - SKID));
      end
      if (|drop) overflow_q <= 1'b1;
    end
  end

  assign busy_fu_o  = busy_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter (default build): vector table, directed corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int unsigned NF = WB_NUM_FU;
  localparam int unsigned D  = WB_DEPTH;
  localparam int unsigned S  = WB_SKID;

  logic                clk = 1'b0;
  logic                rst_n;
  ex_update_t [NF-1:0] fu_update;
  logic [NF-1:0]       busy_fu;
  ex_update_t          wb;
  logic                wb_ready;
  logic                overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .NUM_FU(NF),
    .DEPTH (D),
    .SKID  (S)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fu_update_i(fu_update),
    .busy_fu_o  (busy_fu),
    .wb_o       (wb),
    .wb_ready_i (wb_ready),
    .overflow_o (overflow)
  );

  typedef struct {
    logic       rst;
    logic [3:0] push;
    logic [7:0] base;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_tkt;
    string      name;
  } vec_t;

  vec_t vecs[$];

  ex_update_t   mq [NF][$];
  logic [NF-1:0] mbusy;
  int           mrr;
  logic [7:0]   tk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ex_update_t mk(input logic [7:0] t);
    ex_update_t r;
    r                 = '0;
    r.valid           = 1'b1;
    r.ticket          = t;
    r.data            = {t, ~t, t ^ 8'h5a, 8'h11};
    r.valid_exception = t[0];
    r.cause           = t[4:0];
    return r;
  endfunction

  task automatic chk_wb(input string name, input logic ev, input logic [7:0] et);
    check({name, ".valid"}, 64'(wb.valid), 64'(ev));
    if (ev) check(name, 64'(wb), 64'(mk(et)));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    fu_update = '0;
    wb_ready  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add(input logic r, input logic [3:0] p, input logic [7:0] b, input logic rdy,
                     input logic ev, input logic [7:0] et, input string nm);
    vec_t v;
    v.rst = r; v.push = p; v.base = b; v.ready = rdy;
    v.exp_valid = ev; v.exp_tkt = et; v.name = nm;
    vecs.push_back(v);
  endtask

  initial begin
    rst_n     = 1'b0;
    fu_update = '0;
    wb_ready  = 1'b0;
    @(negedge clk);
    check("reset.valid", 64'(wb.valid), 64'd0);
    check("reset.busy", 64'(busy_fu), 64'd0);
    check("reset.overflow", 64'(overflow), 64'd0);

    // Single FU1 stream: tickets 5,6,7, first visible one cycle after its push.
    add(1, 4'b0000, 8'd0, 1, 0, 8'd0, "single.r");
    add(0, 4'b0010, 8'd4, 1, 0, 8'd0, "single.0");
    add(0, 4'b0010, 8'd5, 1, 1, 8'd5, "single.1");
    add(0, 4'b0010, 8'd6, 1, 1, 8'd6, "single.2");
    add(0, 4'b0000, 8'd0, 1, 1, 8'd7, "single.3");
    add(1, 4'b0000, 8'd0, 1, 0, 8'd0, "single.4");
    // Fairness: all FUs push ticket 16*c+i each cycle; grants rotate 0,1,2,3,...
    for (int c = 0; c < 13; c++) begin
      add(0, (c < 8) ? 4'b1111 : 4'b0000, 8'(16 * c), 1, (c != 0),
          8'(16 * ((c - 1) / 4) + ((c - 1) % 4)), $sformatf("fair.%0d", c));
    end

    foreach (vecs[n]) begin
      chk_wb(vecs[n].name, vecs[n].exp_valid, vecs[n].exp_tkt);
      rst_n    = !vecs[n].rst;
      wb_ready = vecs[n].ready;
      for (int i = 0; i < NF; i++) fu_update[i] = vecs[n].push[i] ? mk(vecs[n].base + 8'(i)) : '0;
      step();
    end
    rst_n     = 1'b1;
    fu_update = '0;

    // Reset mid-operation discards everything, including a push during reset.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      fu_update[0] = mk(8'(100 + k));
      fu_update[3] = (k == 0) ? mk(8'd99) : '0;
      step();
    end
    fu_update = '0;
    check("midrst.busy_pre", 64'(busy_fu[0]), 64'd1);
    chk_wb("midrst.head_pre", 1'b1, 8'd100);
    rst_n        = 1'b0;
    fu_update[1] = mk(8'd77);
    step();
    rst_n     = 1'b1;
    fu_update = '0;
    check("midrst.busy", 64'(busy_fu), 64'd0);
    check("midrst.overflow", 64'(overflow), 64'd0);
    chk_wb("midrst.wb", 1'b0, 8'd0);
    wb_ready = 1'b1;
    step();
    chk_wb("midrst.stale", 1'b0, 8'd0);

    // Backpressure: busy at count 4, SKID more fit, the 9th push overflows.
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      fu_update[0] = mk(8'(120 + k));
      step();
      check($sformatf("bp.busy%0d", k), 64'(busy_fu[0]), 64'(k >= 4));
      check($sformatf("bp.ovf%0d", k), 64'(overflow), 64'(k >= 9));
    end
    fu_update = '0;
    chk_wb("bp.head", 1'b1, 8'd121);

    // Stall stability: output holds while ready=0 and the RR pointer does not move.
    do_reset();
    fu_update[0] = mk(8'd60);
    fu_update[1] = mk(8'd61);
    fu_update[3] = mk(8'd63);
    step();
    fu_update = '0;
    chk_wb("stall0", 1'b1, 8'd60);
    step();
    chk_wb("stall1", 1'b1, 8'd60);
    wb_ready = 1'b1;
    step();
    chk_wb("stall2", 1'b1, 8'd61);
    wb_ready     = 1'b0;
    fu_update[0] = mk(8'd70);
    step();
    fu_update = '0;
    chk_wb("stall3", 1'b1, 8'd61);
    step();
    chk_wb("stall4", 1'b1, 8'd61);
    wb_ready = 1'b1;
    step();
    chk_wb("stall5", 1'b1, 8'd63);
    step();
    chk_wb("stall6", 1'b1, 8'd70);
    step();
    chk_wb("stall7", 1'b0, 8'd0);

    // Full FU2 with push and pop together: no drop, order kept.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      fu_update[2] = mk(8'(40 + k));
      step();
    end
    check("full.busy", 64'(busy_fu[2]), 64'd1);
    chk_wb("full.head", 1'b1, 8'd40);
    fu_update[2] = mk(8'd48);
    wb_ready     = 1'b1;
    step();
    fu_update = '0;
    check("full.ovf", 64'(overflow), 64'd0);
    check("full.busy_after", 64'(busy_fu[2]), 64'd1);
    for (int k = 0; k < 8; k++) begin
      chk_wb($sformatf("full.drain%0d", k), 1'b1, 8'(41 + k));
      step();
    end
    chk_wb("full.empty", 1'b0, 8'd0);

    // Randomized traffic against a queue model; FUs honour busy so nothing is lost.
    do_reset();
    for (int i = 0; i < NF; i++) mq[i].delete();
    mbusy = '0;
    mrr   = 0;
    tk    = 8'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int   g;
      ex_update_t r;
      g = -1;
      for (int k = 0; k < NF; k++) begin
        if (g < 0 && mq[(mrr + k) % NF].size() > 0) g = (mrr + k) % NF;
      end
      if (g >= 0) check($sformatf("rnd.wb%0d", cyc), 64'(wb), 64'(mq[g][0]));
      else        check($sformatf("rnd.valid%0d", cyc), 64'(wb.valid), 64'd0);
      check($sformatf("rnd.busy%0d", cyc), 64'(busy_fu), 64'(mbusy));
      check($sformatf("rnd.ovf%0d", cyc), 64'(overflow), 64'd0);

      wb_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NF; i++) begin
        if (!mbusy[i] && $urandom_range(0, 1) == 1) begin
          r                 = '0;
          r.valid           = 1'b1;
          r.ticket          = tk;
          r.data            = $urandom;
          r.valid_exception = 1'($urandom_range(0, 1));
          r.cause           = 5'($urandom);
          tk                = tk + 8'd1;
          fu_update[i]      = r;
        end else begin
          fu_update[i] = '0;
        end
      end

      if (g >= 0 && wb_ready) begin
        void'(mq[g].pop_front());
        mrr = (g + 1) % NF;
      end
      for (int i = 0; i < NF; i++) begin
        if (fu_update[i].valid && mq[i].size() < D) mq[i].push_back(fu_update[i]);
        mbusy[i] = (mq[i].size() >= D - S);
      end
      step();
    end
    fu_update = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
